// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the uart tx arbitration slice
package uart_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  // (p + k) modulo n for 0 <= p < n and 0 < k <= n, without a divider
  function automatic int wrap_add(int p, int k, int n);
    int s;
    s = p + k;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker starting after ptr
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int LB = 2
)(
  input  logic [N-1:0]  req,
  input  logic [LB-1:0] ptr,
  output logic          found,
  output logic [LB-1:0] idx
);

  // walk ptr+1, ptr+2, ... and take the first requester that is asking
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == wrap_add(int'(ptr), k, N))) begin
          found = 1'b1;
          idx   = LB'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-locked round-robin share of one uart_tx
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int LB_NUM_REQ    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic [LB_NUM_REQ-1:0]         grant_id,
  output logic                          timeout_err,
  output logic [LB_NUM_REQ-1:0]         timeout_id
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [LB_NUM_REQ-1:0] PTR_INIT = LB_NUM_REQ'(NUM_REQ - 1);

  arb_state_t              state;
  logic [LB_NUM_REQ-1:0]   rr_ptr;
  logic [CNT_W-1:0]        idle_cnt;
  logic                    pick_found;
  logic [LB_NUM_REQ-1:0]   pick_idx;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    lock;
  logic                    xfer;
  logic                    timeout_hit;

  uart_rr_pick #(
    .N  (NUM_REQ),
    .LB (LB_NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // select the granted requester's stream signals
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == LB_NUM_REQ'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign lock        = (state == ARB_LOCK);
  assign tx_valid    = lock & sel_valid;
  assign tx_data     = sel_data;
  assign xfer        = tx_valid & tx_ready;
  assign timeout_hit = lock && !sel_valid && (TIMEOUT_CYCLES > 0) && (idle_cnt == CNT_LAST);

  // only the lock holder sees the serializer's ready
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lock && (grant_id == LB_NUM_REQ'(i))) begin
        req_ready[i] = tx_ready;
      end
    end
  end

  // grant, hold until last byte or stall timeout, then hand the pointer on
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ARB_IDLE;
      busy        <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= PTR_INIT;
      timeout_err <= 1'b0;
      timeout_id  <= '0;
      idle_cnt    <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            idle_cnt <= '0;
            state    <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (xfer && sel_last) begin
            state  <= ARB_IDLE;
            rr_ptr <= grant_id;
            busy   <= 1'b0;
          end else if (timeout_hit) begin
            state       <= ARB_IDLE;
            rr_ptr      <= grant_id;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            timeout_id  <= grant_id;
          end else if (sel_valid) begin
            idle_cnt <= '0;
          end else if (idle_cnt != {CNT_W{1'b1}}) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic [1:0]  timeout_id;

  logic        r1_valid;
  logic [7:0]  r1_data;
  logic        r1_last;
  logic        r1_ready;
  logic        t1_valid;
  logic [7:0]  t1_data;
  logic        t1_ready;
  logic        busy1;
  logic        gid1;
  logic        terr1;
  logic        tid1;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt [4];
  int nx;
  int b;

  logic [7:0] t1_bytes [3] = '{8'h41, 8'h42, 8'h43};
  logic [7:0] exp2 [10]    = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h00, 8'h01};
  logic       tr3 [6]      = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] u1_bytes [3] = '{8'hA0, 8'hA1, 8'hB0};
  logic       u1_lasts [3] = '{1'b0, 1'b1, 1'b1};
  logic       exp_tv [6]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] exp_d [6]    = '{8'h00, 8'hA0, 8'hA1, 8'h00, 8'hB0, 8'h00};

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .timeout_id  (timeout_id)
  );

  uart_tx_arbiter #(
    .NUM_REQ        (1),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (0)
  ) dut1 (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (r1_valid),
    .req_data    (r1_data),
    .req_last    (r1_last),
    .req_ready   (r1_ready),
    .tx_valid    (t1_valid),
    .tx_data     (t1_data),
    .tx_ready    (t1_ready),
    .busy        (busy1),
    .grant_id    (gid1),
    .timeout_err (terr1),
    .timeout_id  (tid1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    r1_valid  = 1'b0;
    r1_data   = '0;
    r1_last   = 1'b0;
    t1_ready  = 1'b1;
    #2;
    check("rst_busy",   32'(busy), 0);
    check("rst_grant",  32'(grant_id), 0);
    check("rst_txv",    32'(tx_valid), 0);
    check("rst_ready",  32'(req_ready), 0);
    check("rst_terr",   32'(timeout_err), 0);
    check("rst_tid",    32'(timeout_id), 0);
    tick;
    tick;
    rstn = 1'b1;

    // single requester, three-byte message, serializer always ready
    req_valid = 4'b0001;
    req_data[7:0] = t1_bytes[0];
    tx_ready = 1'b1;
    #1;
    check("t1_latency_txv", 32'(tx_valid), 0);
    check("t1_latency_rdy", 32'(req_ready), 0);
    tick;
    check("t1_busy", 32'(busy), 1);
    check("t1_grant", 32'(grant_id), 0);
    for (int i = 0; i < 3; i++) begin
      req_data[7:0] = t1_bytes[i];
      req_last[0]   = (i == 2);
      #1;
      check("t1_txv", 32'(tx_valid), 1);
      check("t1_data", 32'(tx_data), 32'(t1_bytes[i]));
      check("t1_ready", 32'(req_ready), 32'h1);
      tick;
    end
    check("t1_busy_fall", 32'(busy), 0);
    check("t1_idle_txv", 32'(tx_valid), 0);
    req_valid = '0;
    req_last  = '0;

    // four requesters contend from reset: order 0,1,2,3,0 with whole messages
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    nx = 0;
    for (int cyc = 0; cyc < 40 && nx < 10; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        req_data[i*8 +: 8] = 8'(16 * i + cnt[i]);
        req_last[i]        = (cnt[i] == 1);
      end
      req_valid = 4'hF;
      #1;
      if (tx_valid && tx_ready) begin
        check("t2_byte", 32'(tx_data), 32'(exp2[nx]));
        nx++;
      end
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && req_valid[i]) cnt[i] = (cnt[i] == 1) ? 0 : 1;
      end
      tick;
    end
    check("t2_count", 32'(nx), 10);
    req_valid = '0;
    req_last  = '0;
    #1;
    check("t2_end_busy", 32'(busy), 0);
    check("t2_end_grant", 32'(grant_id), 0);

    // backpressure on req1 while req3 waits; req3 follows
    tick;
    req_valid = 4'b1010;
    req_data[15:8]  = 8'hAA;
    req_data[31:24] = 8'hCC;
    req_last = 4'b1000;
    tx_ready = 1'b0;
    #1;
    check("t3_latency_txv", 32'(tx_valid), 0);
    tick;
    check("t3_grant", 32'(grant_id), 1);
    for (int c = 0; c < 6; c++) begin
      tx_ready = tr3[c];
      req_data[15:8] = (c < 3) ? 8'hAA : 8'hBB;
      req_last[1]    = (c >= 3);
      #1;
      check("t3_txv", 32'(tx_valid), 1);
      check("t3_data", 32'(tx_data), (c < 3) ? 32'hAA : 32'hBB);
      check("t3_ready", 32'(req_ready), {28'd0, 1'b0, tr3[c], 1'b0});
      tick;
    end
    req_valid = 4'b1000;
    #1;
    check("t3_release", 32'(busy), 0);
    tick;
    check("t3_next_grant", 32'(grant_id), 3);
    tx_ready = 1'b1;
    #1;
    check("t3_req3_data", 32'(tx_data), 32'hCC);
    check("t3_req3_ready", 32'(req_ready), 32'h8);
    tick;
    req_valid = '0;
    req_last  = '0;
    check("t3_req3_done", 32'(busy), 0);

    // timeout: req2 sends one non-last byte then stalls, req3 waits
    req_valid = 4'b0100;
    req_data[23:16] = 8'h55;
    tick;
    check("t4_grant", 32'(grant_id), 2);
    #1;
    check("t4_txv", 32'(tx_valid), 1);
    tick;
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    #1;
    check("t4_stall_txv", 32'(tx_valid), 0);
    for (int k = 1; k <= 15; k++) begin
      tick;
      check("t4_hold", {30'd0, busy, timeout_err}, 32'h2);
    end
    tick;
    check("t4_terr", 32'(timeout_err), 1);
    check("t4_tid", 32'(timeout_id), 2);
    check("t4_busy", 32'(busy), 0);
    check("t4_grant_held", 32'(grant_id), 2);
    tick;
    check("t4_terr_pulse", 32'(timeout_err), 0);
    check("t4_next_grant", 32'(grant_id), 3);
    check("t4_next_busy", 32'(busy), 1);
    check("t4_tid_held", 32'(timeout_id), 2);
    tick;
    req_valid = '0;
    req_last  = '0;

    // asynchronous reset in the middle of a req1 message
    req_valid = 4'b0010;
    req_data[15:8] = 8'h77;
    tx_ready = 1'b0;
    tick;
    tx_ready  = 1'b1;
    req_valid = 4'b0011;
    #1;
    check("t5_pre_txv", 32'(tx_valid), 1);
    check("t5_pre_grant", 32'(grant_id), 1);
    check("t5_pre_ready", 32'(req_ready), 32'h2);
    #1;
    rstn = 1'b0;
    #1;
    check("t5_rst_txv", 32'(tx_valid), 0);
    check("t5_rst_ready", 32'(req_ready), 0);
    check("t5_rst_busy", 32'(busy), 0);
    #1;
    rstn = 1'b1;
    tick;
    check("t5_first_grant", 32'(grant_id), 0);
    check("t5_first_busy", 32'(busy), 1);
    req_valid = '0;

    // single-requester build: one idle cycle between back-to-back messages
    b = 0;
    for (int c = 0; c < 6; c++) begin
      r1_valid = (b < 3);
      r1_data  = u1_bytes[(b < 3) ? b : 2];
      r1_last  = u1_lasts[(b < 3) ? b : 2];
      #1;
      check("t6_txv", 32'(t1_valid), 32'(exp_tv[c]));
      if (exp_tv[c]) check("t6_data", 32'(t1_data), 32'(exp_d[c]));
      if (r1_valid && r1_ready) b++;
      tick;
    end
    check("t6_count", 32'(b), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
